// File: rtl/audio_reader_pkg.sv
`default_nettype none
// audio_reader_pkg: state encoding, default widths and burst sizing helper
// shared by the audio burst reader and its sample FIFO.
package audio_reader_pkg;

  localparam int ADDR_W_DEF   = 18;
  localparam int DATA_W_DEF   = 32;
  localparam int BURSTCOUNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FLUSH = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Beats in the next burst: the lesser of the burst cap and the words left.
  function automatic logic [BURSTCOUNT_W-1:0] burst_len(input logic [31:0] max_burst,
                                                        input logic [31:0] rem);
    if (rem < max_burst) return rem[BURSTCOUNT_W-1:0];
    return max_burst[BURSTCOUNT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_sample_fifo.sv
`default_nettype none
// audio_sample_fifo: synchronous FIFO with a registered head word and valid,
// plus a clear input that empties it in one cycle.
module audio_sample_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              push_eff, pop_eff;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop_eff  = pop && !empty && !clear;
  assign push_eff = push && !clear;

  always_comb begin
    rd_ptr_nxt = rd_ptr + PTR_W'(pop_eff);
    count_nxt  = count + CNT_W'(push_eff) - CNT_W'(pop_eff);
    if (clear) begin
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_data  <= '0;
      head_valid <= 1'b0;
    end else begin
      wr_ptr     <= clear ? '0 : wr_ptr + PTR_W'(push_eff);
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
      // A word written into an otherwise empty FIFO bypasses the array read.
      if (count_nxt == '0)                         head_data <= '0;
      else if (push_eff && (wr_ptr == rd_ptr_nxt)) head_data <= push_data;
      else                                         head_data <= mem[rd_ptr_nxt];
      assert (!(push_eff && full && !pop_eff));
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_burst_reader.sv
`default_nettype none
// audio_burst_reader: Avalon-MM burst-read master feeding a valid/ready sample
// stream, issuing only bursts the sample FIFO is guaranteed to absorb.
module audio_burst_reader
  import audio_reader_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_BURST  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       num_words,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       avm_address,
  output logic                    avm_read,
  output logic [BURSTCOUNT_W-1:0] avm_burstcount,
  input  logic                    avm_waitrequest,
  input  logic [DATA_W-1:0]       avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic [DATA_W-1:0]       sample_data,
  output logic                    sample_valid,
  input  logic                    sample_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 2;

  state_t                  state;
  logic [ADDR_W-1:0]       addr, remaining, addr_after, rem_after;
  logic [CNT_W-1:0]        outstanding, out_after, fifo_count;
  logic [BURSTCOUNT_W-1:0] acc_len, next_len;
  logic [SUM_W-1:0]        committed;
  logic                    accept, beat, can_issue;
  logic                    fifo_push, fifo_clear, fifo_full, fifo_empty;

  assign accept     = avm_read && !avm_waitrequest;
  assign acc_len    = accept ? avm_burstcount : '0;
  assign beat       = avm_readdatavalid && (outstanding != '0);
  assign addr_after = addr + ADDR_W'(acc_len);
  assign rem_after  = remaining - ADDR_W'(acc_len);
  assign out_after  = outstanding + CNT_W'(acc_len) - CNT_W'(beat);
  assign next_len   = burst_len(32'(MAX_BURST), 32'(rem_after));

  // Credit: every word already held or still owed, plus the burst just accepted,
  // plus the candidate burst must fit. Pops this cycle are not counted on purpose.
  assign committed = SUM_W'(fifo_count) + SUM_W'(outstanding) + SUM_W'(acc_len) + SUM_W'(next_len);
  assign can_issue = (rem_after != '0) && !fifo_full && (committed <= SUM_W'(FIFO_DEPTH));

  assign fifo_push  = beat && ((state == ST_REQ) || (state == ST_DRAIN));
  assign fifo_clear = (state == ST_FLUSH);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state          <= ST_IDLE;
      addr           <= '0;
      remaining      <= '0;
      outstanding    <= '0;
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_burstcount <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done        <= 1'b0;
      outstanding <= out_after;
      if (accept) begin
        addr      <= addr_after;
        remaining <= rem_after;
      end
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= num_words;
            busy      <= 1'b1;
            state     <= (num_words == '0) ? ST_FIN : ST_REQ;
          end
        end
        ST_REQ: begin
          if (abort) begin
            // A request still stalled by waitrequest stays up until accepted.
            state <= ST_FLUSH;
            if (accept) avm_read <= 1'b0;
          end else if (!avm_read || accept) begin
            if (accept && (rem_after == '0)) begin
              avm_read <= 1'b0;
              state    <= ST_DRAIN;
            end else if (can_issue) begin
              avm_read       <= 1'b1;
              avm_address    <= addr_after;
              avm_burstcount <= next_len;
            end else begin
              avm_read <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (abort)                  state <= ST_FLUSH;
          else if (out_after == '0)   state <= ST_FIN;
        end
        ST_FLUSH: begin
          if (accept) avm_read <= 1'b0;
          if (!avm_read && (out_after == '0) && fifo_empty) state <= ST_FIN;
        end
        ST_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  audio_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk_clk),
    .rst_n      (reset_reset_n),
    .clear      (fifo_clear),
    .push       (fifo_push),
    .push_data  (avm_readdata),
    .pop        (sample_ready),
    .head_data  (sample_data),
    .head_valid (sample_valid),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

endmodule
`default_nettype wire
